txpu_packetizer: RTL and testbench

TXPU_PACKETIZER -- requirements
Module: txpu_packetizer

---
 rtl/txpu_packetizer_if.sv | 21 ++
 rtl/txpu_packetizer.sv | 81 ++++++++
 tb/tb_txpu_packetizer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/txpu_packetizer_if.sv
// txpu_packetizer_if: request, payload-FIFO, transmit-FIFO and line-status signals of the packetizer
interface txpu_packetizer_if;
  logic       send_data;
  logic       send_nak;
  logic       data_fifo_empty;
  logic [7:0] data_fifo_rdata;
  logic       data_fifo_read;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_wdata;
  logic       tx_fifo_write;
  logic       eop_sent;
  logic       is_tx_active;
  modport master (
    input  send_data, send_nak, data_fifo_empty, data_fifo_rdata, tx_fifo_full, eop_sent,
    output data_fifo_read, tx_fifo_wdata, tx_fifo_write, is_tx_active
  );
  modport slave (
    output send_data, send_nak, data_fifo_empty, data_fifo_rdata, tx_fifo_full, eop_sent,
    input  data_fifo_read, tx_fifo_wdata, tx_fifo_write, is_tx_active
  );
endinterface

// File: rtl/txpu_packetizer.sv
// txpu_packetizer: builds USB DATA0/DATA1 (PID, payload, CRC16) and NAK packets into a transmit byte FIFO
module txpu_packetizer #(
  parameter int PAYLOAD_BYTES = 8
) (
  input logic               clk,
  input logic               n_rst,
  txpu_packetizer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD_NAK, LOAD_PID, LOAD_DATA, LOAD_CRC_LO, LOAD_CRC_HI, WAIT_EOP} state_t;
  localparam logic [6:0] LAST = 7'(PAYLOAD_BYTES - 1);
  state_t      state;
  logic        toggle;
  logic        is_nak;
  logic [15:0] crc;
  logic [6:0]  count;
  logic        wr_ok;
  logic        rd;
  // Reflected USB CRC16: one byte folded in eight LSb-first bit steps
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
  assign wr_ok = !bus.tx_fifo_full;
  assign rd = (state == LOAD_DATA) && !bus.data_fifo_empty && wr_ok;
  assign bus.data_fifo_read = rd;
  assign bus.is_tx_active = (state != IDLE);
  assign bus.tx_fifo_write = rd || (wr_ok && (state == LOAD_NAK || state == LOAD_PID ||
                                              state == LOAD_CRC_LO || state == LOAD_CRC_HI));
  assign bus.tx_fifo_wdata = state == LOAD_NAK    ? 8'h5A :
                             state == LOAD_PID    ? (toggle ? 8'h4B : 8'hC3) :
                             state == LOAD_DATA   ? bus.data_fifo_rdata :
                             state == LOAD_CRC_LO ? ~crc[7:0] :
                             state == LOAD_CRC_HI ? ~crc[15:8] : 8'h00;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      toggle <= 1'b0;
      is_nak <= 1'b0;
      crc    <= 16'hFFFF;
      count  <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.send_nak) begin
            state  <= LOAD_NAK;
            is_nak <= 1'b1;
          end else if (bus.send_data) begin
            state  <= LOAD_PID;
            is_nak <= 1'b0;
          end
        end
        LOAD_NAK: if (wr_ok) state <= WAIT_EOP;
        LOAD_PID: begin
          if (wr_ok) begin
            state <= LOAD_DATA;
            crc   <= 16'hFFFF;
            count <= 7'd0;
          end
        end
        LOAD_DATA: begin
          if (rd) begin
            crc   <= crc16_byte(crc, bus.data_fifo_rdata);
            count <= count + 7'd1;
            if (count == LAST) state <= LOAD_CRC_LO;
          end
        end
        LOAD_CRC_LO: if (wr_ok) state <= LOAD_CRC_HI;
        LOAD_CRC_HI: if (wr_ok) state <= WAIT_EOP;
        WAIT_EOP: begin
          if (bus.eop_sent) begin
            state <= IDLE;
            if (!is_nak) toggle <= ~toggle;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_txpu_packetizer.sv
// tb_txpu_packetizer: table vectors, corner-case sequences and random packets against a byte-stream model
module tb_txpu_packetizer;
  localparam int P = 8;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit         sd;
    bit         sn;
    bit         fixed;
    int         stall;
    logic [7:0] first;
    int         nw;
  } vec_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  txpu_packetizer_if bus();
  txpu_packetizer #(.PAYLOAD_BYTES(P)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  bq_t  wq;
  bq_t  pf;
  int   pops;
  bit   st_e, st_f;
  bit   exp_toggle;
  int   total, passed;
  vec_t vt[8];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  // Bitwise MSb-first CRC over bit-reversed input, reflected at the end
  function automatic bq_t build(input bit nak, input bq_t pl);
    bq_t q;
    logic [15:0] c, r;
    if (nak) begin
      q.push_back(8'h5A);
      return q;
    end
    q.push_back(exp_toggle ? 8'h4B : 8'hC3);
    c = 16'hFFFF;
    foreach (pl[k]) begin
      q.push_back(pl[k]);
      for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ pl[k][i]) ? 16'h8005 : 16'h0000);
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    q.push_back(~r[7:0]);
    q.push_back(~r[15:8]);
    return q;
  endfunction
  task automatic step();
    bus.data_fifo_empty = st_e || (pf.size() == 0);
    bus.data_fifo_rdata = (pf.size() != 0) ? pf[0] : 8'h00;
    bus.tx_fifo_full = st_f;
    #1;
    if (bus.tx_fifo_write) wq.push_back(bus.tx_fifo_wdata);
    if (bus.data_fifo_read) begin
      chk("pop_nonempty", int'(bus.data_fifo_empty), 0);
      if (pf.size() != 0) void'(pf.pop_front());
      pops++;
    end
    @(posedge clk);
    #1;
    bus.send_data = 1'b0;
    bus.send_nak = 1'b0;
    bus.eop_sent = 1'b0;
  endtask
  task automatic wait_writes(input int n, input int stall, input int spur);
    int c;
    c = 0;
    while (wq.size() < n && c < 400) begin
      st_e = ($urandom % 100) < stall;
      st_f = ($urandom % 100) < stall;
      if (($urandom % 100) < spur) begin
        bus.send_data = 1'b1;
        bus.send_nak = 1'($urandom);
        bus.eop_sent = 1'($urandom);
      end
      step();
      c++;
    end
    st_e = 1'b0;
    st_f = 1'b0;
  endtask
  task automatic close_packet(input bq_t exp, input bit data, input int stall, input int spur);
    wait_writes(exp.size(), stall, spur);
    repeat (3) begin
      bus.send_data = 1'b1;
      step();
    end
    chk("active_before_eop", int'(bus.is_tx_active), 1);
    bus.eop_sent = 1'b1;
    step();
    chk("active_after_eop", int'(bus.is_tx_active), 0);
    chk("write_count", wq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("byte%0d", i), (i < wq.size()) ? int'(wq[i]) : -1, int'(exp[i]));
    chk("pop_count", pops, data ? P : 0);
    if (data) exp_toggle = ~exp_toggle;
  endtask
  task automatic run_packet(input bit sd, input bit sn, input bit fixed, input int stall, input int spur);
    bq_t pl, exp;
    wq.delete();
    pops = 0;
    if (!sd && !sn) begin
      bus.eop_sent = 1'b1;
      repeat (5) step();
      chk("idle_active", int'(bus.is_tx_active), 0);
      return;
    end
    if (!sn) for (int i = 0; i < P; i++) pl.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    pf = pl;
    exp = build(sn, pl);
    bus.send_data = sd;
    bus.send_nak = sn;
    step();
    close_packet(exp, !sn, stall, spur);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bq_t pl, exp;
    total = 0;
    passed = 0;
    exp_toggle = 1'b0;
    bus.send_data = 1'b0;
    bus.send_nak = 1'b0;
    bus.eop_sent = 1'b0;
    bus.tx_fifo_full = 1'b0;
    bus.data_fifo_empty = 1'b1;
    bus.data_fifo_rdata = 8'h00;
    st_e = 1'b0;
    st_f = 1'b0;
    vt[0] = '{sd:0, sn:1, fixed:0, stall:0,  first:8'h5A, nw:1};
    vt[1] = '{sd:1, sn:0, fixed:1, stall:0,  first:8'hC3, nw:P+3};
    vt[2] = '{sd:1, sn:0, fixed:0, stall:0,  first:8'h4B, nw:P+3};
    vt[3] = '{sd:1, sn:1, fixed:0, stall:0,  first:8'h5A, nw:1};
    vt[4] = '{sd:1, sn:0, fixed:0, stall:30, first:8'hC3, nw:P+3};
    vt[5] = '{sd:0, sn:1, fixed:0, stall:50, first:8'h5A, nw:1};
    vt[6] = '{sd:0, sn:0, fixed:0, stall:0,  first:8'h00, nw:0};
    vt[7] = '{sd:1, sn:0, fixed:0, stall:50, first:8'h4B, nw:P+3};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", int'(bus.is_tx_active), 0);
    chk("rst_write", int'(bus.tx_fifo_write), 0);
    chk("rst_read", int'(bus.data_fifo_read), 0);
    chk("rst_wdata", int'(bus.tx_fifo_wdata), 0);
    n_rst = 1'b1;
    foreach (vt[i]) begin
      run_packet(vt[i].sd, vt[i].sn, vt[i].fixed, vt[i].stall, 10);
      chk($sformatf("vec%0d_nw", i), wq.size(), vt[i].nw);
      if (vt[i].nw > 0) chk($sformatf("vec%0d_first", i), (wq.size() != 0) ? int'(wq[0]) : -1, int'(vt[i].first));
    end
    // payload runs dry after 3 bytes, then transmit FIFO fills during CRC
    pl.delete();
    for (int i = 0; i < P; i++) pl.push_back(8'($urandom));
    exp = build(1'b0, pl);
    wq.delete();
    pops = 0;
    pf.delete();
    for (int i = 0; i < 3; i++) pf.push_back(pl[i]);
    bus.send_data = 1'b1;
    step();
    wait_writes(4, 0, 0);
    repeat (10) step();
    chk("empty_stall_writes", wq.size(), 4);
    for (int i = 3; i < P; i++) pf.push_back(pl[i]);
    wait_writes(P + 1, 0, 0);
    st_f = 1'b1;
    repeat (5) step();
    st_f = 1'b0;
    chk("full_stall_writes", wq.size(), P + 1);
    close_packet(exp, 1'b1, 0, 0);
    // reset in the middle of a DATA1 payload
    chk("toggle_is_data1", int'(exp_toggle), 1);
    for (int i = 0; i < P; i++) pl[i] = 8'($urandom);
    wq.delete();
    pf = pl;
    bus.send_data = 1'b1;
    step();
    wait_writes(3, 0, 0);
    chk("mid_first", (wq.size() != 0) ? int'(wq[0]) : -1, 8'h4B);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_active", int'(bus.is_tx_active), 0);
    chk("mid_rst_write", int'(bus.tx_fifo_write), 0);
    repeat (2) step();
    chk("mid_rst_no_writes", wq.size(), 3);
    n_rst = 1'b1;
    exp_toggle = 1'b0;
    pf.delete();
    run_packet(1'b1, 1'b0, 1'b0, 0, 0);
    chk("post_rst_pid", (wq.size() != 0) ? int'(wq[0]) : -1, 8'hC3);
    for (int n = 0; n < 25; n++) begin
      int sel;
      sel = int'($urandom % 4);
      run_packet(sel != 0, sel == 3, 1'b0, int'($urandom % 40), int'($urandom % 20));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
